// File: rtl/rsa_host_if.sv
// Host command/data front-end for the RSA core: command decode, beat-wise operand
// loading into N_SLOTS registers, core dispatch with timeout, and beat-wise result readback.
module rsa_host_if #(
    parameter int OP_W    = 1024,
    parameter int BUS_W   = 256,
    parameter int N_SLOTS = 4,
    parameter int TIMEOUT = 65536
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               arm_to_fpga_cmd,
    input  logic                      arm_to_fpga_cmd_valid,
    output logic                      fpga_to_arm_done,
    input  logic                      fpga_to_arm_done_read,
    input  logic                      arm_to_fpga_data_valid,
    output logic                      arm_to_fpga_data_ready,
    input  logic [BUS_W-1:0]          arm_to_fpga_data,
    output logic                      fpga_to_arm_data_valid,
    input  logic                      fpga_to_arm_data_ready,
    output logic [BUS_W-1:0]          fpga_to_arm_data,
    output logic [N_SLOTS*OP_W-1:0]   operands,
    output logic                      op_start,
    output logic [3:0]                op_mode,
    input  logic                      core_done,
    input  logic [OP_W-1:0]           core_result,
    output logic [3:0]                leds,
    output logic [2:0]                dbg_state
);

    localparam int BEATS = OP_W / BUS_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   slot_q [N_SLOTS];
    logic [OP_W-1:0]   slot_d [N_SLOTS];
    logic [OP_W-1:0]   result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              error_q, error_d;
    logic [3:0]        mode_q, mode_d;
    logic [SW-1:0]     slot_sel_q, slot_sel_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [3:0]        opcode;
    logic              unused_cmd_bits;

    assign opcode          = arm_to_fpga_cmd[3:0];
    assign unused_cmd_bits = ^arm_to_fpga_cmd[31:12];

    // Both data handshakes: a beat transfers on a rising edge where valid and ready are
    // both 1; the source holds its beat stable while valid=1 and ready=0.
    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        error_d        = error_q;
        mode_d         = mode_q;
        slot_sel_d     = slot_sel_q;
        beat_d         = beat_q;
        tcnt_d         = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    error_d = 1'b0;
                    beat_d  = '0;
                    case (opcode)
                        4'h0: begin
                            if (32'(arm_to_fpga_cmd[7:4]) < N_SLOTS) begin
                                slot_sel_d = SW'(arm_to_fpga_cmd[7:4]);
                                state_d    = S_LOAD;
                            end else begin
                                error_d = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        4'h1: begin
                            mode_d  = arm_to_fpga_cmd[11:8];
                            state_d = S_START;
                        end
                        4'h2: state_d = S_SEND;
                        4'h3: begin
                            for (int s = 0; s < N_SLOTS; s++) slot_d[s] = '0;
                            result_d       = '0;
                            result_valid_d = 1'b0;
                            state_d        = S_DONE;
                        end
                        default: begin
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (arm_to_fpga_data_valid) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_q == BW'(b)) slot_d[slot_sel_q][b*BUS_W +: BUS_W] = arm_to_fpga_data;
                    end
                    if (beat_q == BW'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    result_d       = core_result;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (fpga_to_arm_data_ready) begin
                    if (beat_q == BW'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (fpga_to_arm_done_read) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            for (int s = 0; s < N_SLOTS; s++) slot_q[s] <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            mode_q         <= '0;
            slot_sel_q     <= '0;
            beat_q         <= '0;
            tcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            mode_q         <= mode_d;
            slot_sel_q     <= slot_sel_d;
            beat_q         <= beat_d;
            tcnt_q         <= tcnt_d;
        end
    end

    always_comb begin
        fpga_to_arm_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) fpga_to_arm_data = result_q[b*BUS_W +: BUS_W];
        end
    end

    for (genvar s = 0; s < N_SLOTS; s++) begin : g_operands
        assign operands[s*OP_W +: OP_W] = slot_q[s];
    end

    assign arm_to_fpga_data_ready = (state_q == S_LOAD);
    assign fpga_to_arm_data_valid = (state_q == S_SEND);
    assign op_start               = (state_q == S_START);
    assign fpga_to_arm_done       = (state_q == S_DONE);
    assign op_mode                = mode_q;
    assign leds                   = {error_q, state_q != S_IDLE, fpga_to_arm_done, result_valid_q};
    assign dbg_state              = state_q;

endmodule

// File: doc/rsa_host_if.md
# rsa_host_if

Parametrised host-side command/data front-end for the RSA accelerator. It accepts 32-bit commands from the ARM, streams operands in BUS_W-bit beats into N_SLOTS operand registers of OP_W bits, dispatches a compute operation to the core with a selectable mode, and streams the result back in beats. It generalises the fixed single-beat, fixed-operand host interface to configurable bus width, operand width and slot count. It adds error reporting and a core-timeout watchdog.

## Interface
- OP_W, 1024, operand/result width in bits; must be a multiple of BUS_W
- BUS_W, 256, host data bus width; BEATS = OP_W/BUS_W
- N_SLOTS, 4, number of operand registers (1..16)
- TIMEOUT, 65536, maximum WAIT_CORE cycles before an error abort
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- arm_to_fpga_cmd  in  32  command: [3:0] opcode, [7:4] slot, [11:8] mode
- arm_to_fpga_cmd_valid  in  1  command strobe
- fpga_to_arm_done  out  1  command complete; held until acknowledged
- fpga_to_arm_done_read  in  1  done acknowledge
- arm_to_fpga_data_valid / arm_to_fpga_data_ready  in / out  1 / 1  input beat handshake
- arm_to_fpga_data  in  BUS_W  input beat
- fpga_to_arm_data_valid / fpga_to_arm_data_ready  out / in  1 / 1  output beat handshake
- fpga_to_arm_data  out  BUS_W  output beat
- operands  out  N_SLOTS*OP_W  slot s occupies bits [s*OP_W +: OP_W]
- op_start  out  1  one-cycle core start pulse
- op_mode  out  4  mode latched from cmd[11:8]
- core_done  in  1  core completion pulse
- core_result  in  OP_W  valid when core_done is high
- leds  out  4  {error, busy, done, result_valid}

## Operation
- States: IDLE, LOAD, START, WAIT_CORE, SEND, DONE.
- A command is accepted only in IDLE, on a rising edge with cmd_valid=1. A cmd_valid in any other state is ignored: no state change, no error.
- Opcode 0x0 LOAD: if slot < N_SLOTS, go to LOAD. Otherwise set error and go to DONE.
- Opcode 0x1 COMPUTE: latch op_mode, then go to START.
- Opcode 0x2 READ: go to SEND.
- Opcode 0x3 CLEAR: zero all slots, the result and result_valid; clear error; go to DONE.
- Any other opcode: set error and go to DONE.
- Error semantics:
  - The error flag is sticky until the next accepted command, which clears it.
  - LOAD, COMPUTE and READ also clear error on acceptance.
  - An out-of-range slot leaves all slots unchanged.
- LOAD:
  - arm_to_fpga_data_ready=1 throughout the state.
  - Each valid&ready beat writes slot[s][beat*BUS_W +: BUS_W], least-significant beat first.
  - The beat counter runs 0..BEATS-1. After the last beat, go to DONE.
- START: op_start=1 for exactly one cycle, then go to WAIT_CORE and clear the timeout counter.
- WAIT_CORE:
  - core_done=1 latches core_result into the result register, sets result_valid, and goes to DONE.
  - The timeout counter reaching TIMEOUT-1 without core_done sets error, leaves result and result_valid unchanged, and goes to DONE.
  - core_done outside WAIT_CORE is ignored.
- SEND:
  - fpga_to_arm_data_valid=1 and fpga_to_arm_data = result[beat*BUS_W +: BUS_W].
  - The beat advances on valid&ready. After the last beat, go to DONE.
  - SEND does not depend on result_valid: it sends the current register contents, which are zero after reset or CLEAR.
- DONE: fpga_to_arm_done=1 until a cycle with done_read=1, then go to IDLE.
- busy = (state != IDLE). done in leds mirrors fpga_to_arm_done.

## Timing
- Reset: all outputs 0, state IDLE, slots, result, counters and flags zero. Reset asserted mid-operation aborts immediately, with no partial completion and no done.
- Command latency: accepted at edge k; the new state is visible from cycle k+1.
- COMPUTE:
  - op_start is high during cycle k+1.
  - WAIT_CORE starts at k+2.
  - core_done sampled at edge j gives done=1 from cycle j+1.
- LOAD: ready rises in cycle k+1. With valid held high, BEATS beats take BEATS cycles, and done follows the cycle after the last beat.
- SEND: the first beat is valid in cycle k+1. Data stays stable while valid=1 and ready=0.
- DONE to IDLE: done falls in the cycle after done_read is sampled. A new command is accepted from that IDLE cycle onward.
- A cmd_valid coincident with done_read in DONE is ignored.

## Test plan
- LOAD slot 1, beats 256'h11..11, 22..22, 33..33, 44..44 with valid held high -> operands[2047:1024] = {44..,33..,22..,11..}; done 1 cycle after the 4th beat, held until done_read; other slots 0.
- COMPUTE mode 4, core model asserts core_done 10 cycles after op_start with result 1024'hABCD -> op_start one cycle, op_mode=4, done at the cycle after core_done, result_valid=1.
- READ with fpga_to_arm_data_ready toggling 1/0 -> 4 beats, LS first, 0xABCD in beat 0, no duplicates or drops, data stable during stalls.
- LOAD slot 7 (N_SLOTS=4) and opcode 0xF -> error=1, done asserted, no data_ready, slots unchanged. A following valid CLEAR clears error.
- TIMEOUT=64, core never responds -> done exactly 64 cycles after WAIT_CORE entry, error=1, result_valid unchanged.
- Assert reset after 2 of 4 LOAD beats, plus cmd_valid pulses while busy -> all outputs 0 and slots zero; busy commands ignored.
